// File: rtl/seq_pkg.sv
// Shared types for the serial sequence path (serializer and detector).
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } ser_state_t;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding seq_detect.din: accepts a WIDTH-bit word
// over valid/ready and drives it one bit per clock on sout, resting at
// IDLE_LEVEL between words and for GAP_CYCLES optional gap cycles.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] LAST_CNT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_busy;
  logic             r_word_done;

  logic             w_last_bit;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_first_rest;
  logic [WIDTH-1:0] w_shift_next;

  // The shift register holds only the bits not yet on sout: the first bit
  // goes straight to the sout register on accept, so there is no load bubble.
  assign w_first_bit  = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
  assign w_first_rest = (MSB_FIRST != 0) ? {data_in[WIDTH-2:0], 1'b0}
                                         : {1'b0, data_in[WIDTH-1:1]};
  assign w_next_bit   = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_shift[WIDTH-1:1]};

  assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == LAST_CNT);
  assign data_ready = !rst && ((r_state == S_IDLE) ||
                               (w_last_bit && (GAP_CYCLES == 0)));
  assign w_accept   = data_valid && data_ready;

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = r_busy;
  assign word_done  = r_word_done;

  // FSM with shift register, bit/gap counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_SHIFT;
            r_shift      <= w_first_rest;
            r_bit_cnt    <= '0;
            r_sout       <= w_first_bit;
            r_sout_valid <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (!w_last_bit) begin
            r_bit_cnt   <= r_bit_cnt + 1'b1;
            r_shift     <= w_shift_next;
            r_sout      <= w_next_bit;
            r_word_done <= (r_bit_cnt == PRE_LAST);
          end else if (GAP_CYCLES > 0) begin
            r_state      <= S_GAP;
            r_gap_cnt    <= '0;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
          end else if (w_accept) begin
            r_shift   <= w_first_rest;
            r_bit_cnt <= '0;
            r_sout    <= w_first_bit;
          end else begin
            r_state      <= S_IDLE;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_sout       <= IDLE_LEVEL;
          r_sout_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: default, GAP_CYCLES=2 and LSB-first builds.
module tb_seq_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;

  logic d_ready, d_sout, d_svalid, d_busy, d_done;
  logic g_ready, g_sout, g_svalid, g_busy, g_done;
  logic l_ready, l_sout, l_svalid, l_busy, l_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] pat;

  seq_serializer u_def (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(d_ready), .sout(d_sout), .sout_valid(d_svalid),
    .busy(d_busy), .word_done(d_done)
  );

  seq_serializer #(.GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(g_ready), .sout(g_sout), .sout_valid(g_svalid),
    .busy(g_busy), .word_done(g_done)
  );

  seq_serializer #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_ready), .sout(l_sout), .sout_valid(l_svalid),
    .busy(l_busy), .word_done(l_done)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;

    // 1. reset
    #2 rst = 1'b1;
    #1;
    chk("rst_sout", d_sout, 1'b1);
    chk("rst_svalid", d_svalid, 1'b0);
    chk("rst_busy", d_busy, 1'b0);
    chk("rst_done", d_done, 1'b0);
    chk("rst_ready", d_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_ready_edge", d_ready, 1'b0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rel_ready", d_ready, 1'b1);
    chk("rel_sout", d_sout, 1'b1);

    // 2. single word A5, MSB first
    pat = 16'h00A5;
    @(negedge clk);
    data_in = 8'hA5; data_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk($sformatf("a5_bit%0d", j), d_sout, pat[7-j]);
      chk($sformatf("a5_sv%0d", j), d_svalid, 1'b1);
      chk($sformatf("a5_busy%0d", j), d_busy, 1'b1);
      chk($sformatf("a5_done%0d", j), d_done, (j == 7));
      chk($sformatf("a5_rdy%0d", j), d_ready, (j == 7));
      @(negedge clk) data_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("a5_idle_sout", d_sout, 1'b1);
    chk("a5_idle_sv", d_svalid, 1'b0);
    chk("a5_idle_busy", d_busy, 1'b0);
    chk("a5_idle_rdy", d_ready, 1'b1);

    // 3. back-to-back F0 then 0F
    pat = 16'hF00F;
    @(negedge clk);
    data_in = 8'hF0; data_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_bit%0d", j), d_sout, pat[15-j]);
      chk($sformatf("b2b_sv%0d", j), d_svalid, 1'b1);
      chk($sformatf("b2b_rdy%0d", j), d_ready, (j == 7 || j == 15));
      chk($sformatf("b2b_done%0d", j), d_done, (j == 7 || j == 15));
      @(negedge clk);
      if (j == 0) data_in = 8'h0F;
      if (j == 8) data_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_idle_sout", d_sout, 1'b1);
    chk("b2b_idle_sv", d_svalid, 1'b0);

    // 4. GAP_CYCLES=2: FF, gap, idle accept, 00, gap
    @(negedge clk);
    data_in = 8'hFF; data_valid = 1'b1;
    for (int j = 0; j < 21; j++) begin
      @(posedge clk); #1;
      if (j < 8) begin
        chk($sformatf("gap_w1_bit%0d", j), g_sout, 1'b1);
        chk($sformatf("gap_w1_sv%0d", j), g_svalid, 1'b1);
        chk($sformatf("gap_w1_rdy%0d", j), g_ready, 1'b0);
      end else if (j < 10 || j > 18) begin
        chk($sformatf("gap_sout%0d", j), g_sout, 1'b1);
        chk($sformatf("gap_sv%0d", j), g_svalid, 1'b0);
        chk($sformatf("gap_busy%0d", j), g_busy, 1'b1);
        chk($sformatf("gap_rdy%0d", j), g_ready, 1'b0);
      end else if (j == 10) begin
        chk("gap_idle_sout", g_sout, 1'b1);
        chk("gap_idle_busy", g_busy, 1'b0);
        chk("gap_idle_rdy", g_ready, 1'b1);
      end else begin
        chk($sformatf("gap_w2_bit%0d", j), g_sout, 1'b0);
        chk($sformatf("gap_w2_sv%0d", j), g_svalid, 1'b1);
        chk($sformatf("gap_w2_done%0d", j), g_done, (j == 18));
      end
      @(negedge clk);
      if (j == 0) data_in = 8'h00;
      if (j == 11) data_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("gap_end_busy", g_busy, 1'b0);
    chk("gap_end_rdy", g_ready, 1'b1);

    // 5. LSB first: 01 -> 1 then seven 0s
    @(negedge clk);
    data_in = 8'h01; data_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk($sformatf("lsb_bit%0d", j), l_sout, (j == 0));
      chk($sformatf("lsb_sv%0d", j), l_svalid, 1'b1);
      @(negedge clk) data_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("lsb_idle_sout", l_sout, 1'b1);

    // 6. reset mid-word, then clean restart
    pat = 16'h00C3;
    @(negedge clk);
    data_in = 8'hC3; data_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk($sformatf("c3_bit%0d", j), d_sout, pat[7-j]);
      @(negedge clk) data_valid = 1'b0;
    end
    @(posedge clk); #5;
    rst = 1'b1;
    #1;
    chk("mid_rst_sout", d_sout, 1'b1);
    chk("mid_rst_sv", d_svalid, 1'b0);
    chk("mid_rst_busy", d_busy, 1'b0);
    chk("mid_rst_rdy", d_ready, 1'b0);
    @(negedge clk) rst = 1'b0;
    pat = 16'h003C;
    @(negedge clk);
    data_in = 8'h3C; data_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk($sformatf("3c_bit%0d", j), d_sout, pat[7-j]);
      chk($sformatf("3c_done%0d", j), d_done, (j == 7));
      @(negedge clk) data_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
